// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_ctrl
// Purpose  : HI/LO register sequencer for the execute stage. Runs a registered
//            32x32 multiply, a 32-step restoring divide with sign fix-up, or a
//            direct MTHI/MTLO move. Each op produces a single HI/LO write pulse.
//            A busy/ready handshake stalls the pipeline, and a flush cancels
//            the op in flight.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_ctrl #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,       // active-high synchronous reset despite the name
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        cancel,
  input  logic [63:0] hilo_cur,
  output logic        ready,
  output logic        busy,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        div_zero
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [4:0] CNT_LAST = 5'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] product;
  logic [31:0] quo;       // dividend shifts out, quotient bits shift in
  logic [31:0] rem;       // partial remainder, always < divisor after a step
  logic [31:0] divisor;
  logic        sign_q;
  logic        sign_r;

  logic [63:0] eff_hilo;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_p;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Operand preparation, one restoring-divide step and the final sign fix-up
  always_comb begin
    // A write leaving this cycle is newer than hilo_cur, so forward it
    eff_hilo = hilo_we ? hilo_wdata : hilo_cur;

    // Extending both operands to 64 bits gives the correct low 64 product
    // bits for the signed and the unsigned case alike
    mul_a = (op == OP_MULT) ? {{32{operand_a[31]}}, operand_a} : {32'h0, operand_a};
    mul_b = (op == OP_MULT) ? {{32{operand_b[31]}}, operand_b} : {32'h0, operand_b};
    mul_p = mul_a * mul_b;

    a_neg = (op == OP_DIV) && operand_a[31];
    b_neg = (op == OP_DIV) && operand_b[31];
    a_abs = a_neg ? (32'd0 - operand_a) : operand_a;
    b_abs = b_neg ? (32'd0 - operand_b) : operand_b;

    // A borrow out of bit 32 means the trial subtraction failed and the
    // shifted remainder is restored
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, divisor};

    quo_fix = sign_q ? (32'd0 - quo) : quo;
    rem_fix = sign_r ? (32'd0 - rem) : rem;
  end

  // Sequencer FSM with registered handshake and write strobes
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= ST_IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      hilo_we    <= 1'b0;
      hilo_wdata <= 64'h0;
      div_zero   <= 1'b0;
      cnt        <= 5'd0;
      product    <= 64'h0;
      quo        <= 32'h0;
      rem        <= 32'h0;
      divisor    <= 32'h0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
    end else begin
      hilo_we  <= 1'b0;
      div_zero <= 1'b0;
      if (cancel) begin
        // Flush: drop the op; the strobes stay low next cycle
        state <= ST_IDLE;
        ready <= 1'b1;
        busy  <= 1'b0;
        cnt   <= 5'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (op_valid) begin
              case (op)
                OP_MULT, OP_MULTU: begin
                  product <= mul_p;
                  state   <= ST_MUL;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                  if (operand_b == 32'h0) begin
                    div_zero <= 1'b1;
                  end else begin
                    quo     <= a_abs;
                    rem     <= 32'h0;
                    divisor <= b_abs;
                    sign_q  <= a_neg ^ b_neg;
                    sign_r  <= a_neg;
                    cnt     <= 5'd0;
                    state   <= ST_DIV;
                    ready   <= 1'b0;
                    busy    <= 1'b1;
                  end
                end
                OP_MTHI: begin
                  hilo_we    <= 1'b1;
                  hilo_wdata <= {operand_a, eff_hilo[31:0]};
                end
                OP_MTLO: begin
                  hilo_we    <= 1'b1;
                  hilo_wdata <= {eff_hilo[63:32], operand_a};
                end
                default: ;  // NOP and reserved encodings are consumed silently
              endcase
            end
          end
          ST_MUL: begin
            hilo_we    <= 1'b1;
            hilo_wdata <= product;
            state      <= ST_IDLE;
            ready      <= 1'b1;
            busy       <= 1'b0;
          end
          ST_DIV: begin
            if (!diff[32]) begin
              rem <= diff[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= shifted[31:0];
              quo <= {quo[30:0], 1'b0};
            end
            if (cnt == CNT_LAST) begin
              cnt   <= 5'd0;
              state <= ST_FIX;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          ST_FIX: begin
            hilo_we    <= 1'b1;
            hilo_wdata <= {rem_fix, quo_fix};
            state      <= ST_IDLE;
            ready      <= 1'b1;
            busy       <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
